bcd_stopwatch_ctrl: RTL and testbench
=====================================

# bcd_stopwatch_ctrl

Run/stop/lap/clear controller that sequences a chain of DIGITS synchronous BCD digit counters from a prescaled tick. It owns the enable and carry sequencing, clearing, wrap/overflow detection and lap capture. It sits between the push-button pulse logic and the 7-segment display driver, and presents a live or frozen packed-BCD value.

## Interface
- DIGITS, 4: number of cascaded BCD digits; digit 0 is least significant; legal range 1..8.
- TICK_DIV, 10: clock cycles per count increment; legal range ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start_stop  in  1  one-cycle command pulse: start or resume, and stop.
- lap  in  1  one-cycle command pulse: freeze or release the display.
- clear  in  1  one-cycle command pulse: zero everything and return to IDLE.
- count  out  4*DIGITS  live packed BCD value; digit k is at [4k+3:4k].
- display  out  4*DIGITS  lap_reg while lap_active=1, otherwise count (combinational mux).
- running  out  1  high in RUN and LAP.
- lap_active  out  1  high in LAP.
- overflow  out  1  sticky; set when the chain wraps from all-9s to 0.

## Operation
- Commands are level-sampled every clock with no edge detection. A command held high acts on every cycle.
- Command priority in a single cycle: clear > start_stop > lap. A lower-priority command in the same cycle is dropped.
- States and transitions:
  - IDLE: start_stop → RUN; lap is ignored.
  - RUN: start_stop → STOP; lap → LAP and captures lap_reg.
  - LAP: lap → RUN (display goes live again); start_stop → STOP (lap_active drops).
  - STOP: start_stop → RUN; lap is ignored.
  - clear in any state → IDLE. This zeroes all digits, the prescaler, lap_reg and overflow.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN and LAP.
  - tick is asserted when the prescaler is at TICK_DIV-1 in RUN or LAP; the prescaler then returns to 0.
  - The prescaler holds its value in STOP, so resume keeps the phase.
- Digit chain:
  - Digit k increments on tick when digits 0..k-1 are all 9.
  - A digit at 9 that increments goes to 0.
  - Digit values 10–15 cannot occur; no recovery logic is required.
- Wrap: a tick with all digits at 9 gives count=0 and sets overflow=1. Counting continues; overflow stays set until clear or rst.
- lap_reg captures the pre-edge count, i.e. the value before any same-edge increment.

## Timing
- Reset values while rst is high, applied asynchronously:
  - state=IDLE
  - count=0, display=0
  - prescaler=0, lap_reg=0
  - running=0, lap_active=0, overflow=0
- A start_stop accepted at edge N puts the block in RUN from edge N. The first increment lands at edge N+TICK_DIV, and every TICK_DIV cycles after that.
- A stop at edge M freezes count at edge M. A tick that would land at edge M is suppressed.
- count, running, lap_active and overflow are registered. display follows lap_active and lap_reg with zero added latency.
- clear applies at the next edge and overrides a tick on the same edge.
- If rst asserts mid-run, all outputs go to their reset values immediately, without waiting for a clock. After release, the block waits in IDLE for start_stop.

## Structure
- Package bcd_sw_pkg:
  - state enum {IDLE, RUN, STOP, LAP}
  - BCD_MAX = 4'd9
  - the command priority encoding
- Sub-module bcd_digit_en, instantiated DIGITS times:
  - Ports: clk, rst (async, active-high), clr (sync), en, q[3:0], co.
  - co = en & (q==9).
  - The carry chain is en[k+1] = co[k], with en[0] = tick.
- The top level holds the FSM, the prescaler, lap_reg and the overflow flag.

## Test plan
- DIGITS=2, TICK_DIV=4: pulse start_stop at edge N → count=0x01 at edge N+4 and count=0x10 at edge N+40; running=1 throughout.
- Preload the chain to 0x99 by running 396 cycles, then wait for the next tick → count=0x00 and overflow=1. overflow stays 1 after a further tick and clears on a clear pulse.
- lap pulse at count=0x05 → display=0x05 and lap_active=1 while count reaches 0x08. A second lap pulse → display tracks count and lap_active=0.
- start_stop at prescaler=2 (STOP), idle 20 cycles, start_stop again → next increment exactly 2 cycles after resume; count unchanged during STOP.
- clear and start_stop in the same cycle while in RUN at count=0x37 → IDLE, count=0, running=0. lap and start_stop in the same cycle in RUN → STOP, lap_reg unchanged.
- Assert rst between clock edges in LAP at count=0x12 → count, display and all flags are 0 before the next edge. After release, no counting until start_stop.

Source files
------------

// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// Shared types for the BCD stopwatch controller: FSM states, BCD limit and
// the command priority encoding used by the control path.
package bcd_sw_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP,
        LAP
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_CLEAR,
        CMD_START_STOP,
        CMD_LAP
    } cmd_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Only one command survives per cycle: clear beats start_stop beats lap.
    function automatic cmd_t decodeCmd(input logic clearIn,
                                       input logic startStopIn,
                                       input logic lapIn);
        cmd_t cmd;
        cmd = CMD_NONE;
        if (clearIn)
            cmd = CMD_CLEAR;
        else if (startStopIn)
            cmd = CMD_START_STOP;
        else if (lapIn)
            cmd = CMD_LAP;
        return cmd;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Command and display bundle between the button pulse logic (master) and the
// stopwatch controller (slave).
interface bcd_stopwatch_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  start_stop;
    logic                  lap;
    logic                  clear;
    logic [4*DIGITS-1:0]   count;
    logic [4*DIGITS-1:0]   display;
    logic                  running;
    logic                  lap_active;
    logic                  overflow;

    modport master (
        output start_stop, lap, clear,
        input  count, display, running, lap_active, overflow
    );

    modport slave (
        input  start_stop, lap, clear,
        output count, display, running, lap_active, overflow
    );
endinterface

// File: rtl/bcd_stopwatch_ctrl_digit_en.sv
// One synchronous BCD digit with count enable; co ripples into the next digit.
module bcd_digit_en
    import bcd_sw_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] q,
    output logic       co
);

    logic [3:0] q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q_q <= 4'd0;
        else if (clr)
            q_q <= 4'd0;
        else if (en)
            q_q <= (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
    end

    assign q  = q_q;
    assign co = en & (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/stop/lap/clear controller: FSM, prescaler, lap capture and overflow
// flag driving a cascade of bcd_digit_en counters.
module bcd_stopwatch_ctrl
    import bcd_sw_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_stopwatch_ctrl_if.slave  sw
);

    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    state_t              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [4*DIGITS-1:0] lapReg_q, lapReg_d;
    logic                overflow_q, overflow_d;
    logic                running_q, lapActive_q;

    cmd_t                cmd;
    logic                active;
    logic                tick;
    logic [DIGITS-1:0]   en;
    logic [DIGITS-1:0]   co;
    logic [4*DIGITS-1:0] countW;

    assign cmd    = decodeCmd(sw.clear, sw.start_stop, sw.lap);
    assign active = (state_q == RUN) || (state_q == LAP);

    // A stop or clear landing on the tick edge swallows that tick.
    assign tick = active && (presc_q == PRESC_MAX)
                  && (cmd != CMD_CLEAR) && (cmd != CMD_START_STOP);

    always_comb begin
        state_d = state_q;
        unique case (cmd)
            CMD_CLEAR: state_d = IDLE;
            CMD_START_STOP: begin
                unique case (state_q)
                    IDLE, STOP: state_d = RUN;
                    RUN, LAP:   state_d = STOP;
                    default:    state_d = IDLE;
                endcase
            end
            CMD_LAP: begin
                if (state_q == RUN)
                    state_d = LAP;
                else if (state_q == LAP)
                    state_d = RUN;
            end
            default: state_d = state_q;
        endcase
    end

    // Prescaler freezes outside RUN/LAP so a resume keeps its phase.
    always_comb begin
        presc_d    = presc_q;
        lapReg_d   = lapReg_q;
        overflow_d = overflow_q;
        if (cmd == CMD_CLEAR) begin
            presc_d    = '0;
            lapReg_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (active && (cmd != CMD_START_STOP))
                presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
            if ((state_q == RUN) && (cmd == CMD_LAP))
                lapReg_d = countW;
            if (co[DIGITS-1])
                overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            lapReg_q    <= '0;
            overflow_q  <= 1'b0;
            running_q   <= 1'b0;
            lapActive_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            lapReg_q    <= lapReg_d;
            overflow_q  <= overflow_d;
            running_q   <= (state_d == RUN) || (state_d == LAP);
            lapActive_q <= (state_d == LAP);
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        if (k == 0) begin : g_first
            assign en[k] = tick;
        end else begin : g_rest
            assign en[k] = co[k-1];
        end

        bcd_digit_en u_digit (
            .clk (clk),
            .rst (rst),
            .clr (cmd == CMD_CLEAR),
            .en  (en[k]),
            .q   (countW[4*k +: 4]),
            .co  (co[k])
        );
    end

    assign sw.count      = countW;
    assign sw.display    = lapActive_q ? lapReg_q : countW;
    assign sw.running    = running_q;
    assign sw.lap_active = lapActive_q;
    assign sw.overflow   = overflow_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl with DIGITS=2, TICK_DIV=4; inputs are
// driven and outputs sampled on the falling edge.
module tb_bcd_stopwatch_ctrl;

    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    bcd_stopwatch_ctrl_if #(.DIGITS(DIGITS)) sw ();

    bcd_stopwatch_ctrl #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Holds the given commands for exactly one rising edge.
    task automatic applyStimulus(input logic ss, input logic lp, input logic clr);
        sw.start_stop = ss;
        sw.lap        = lp;
        sw.clear      = clr;
        @(negedge clk);
        sw.start_stop = 1'b0;
        sw.lap        = 1'b0;
        sw.clear      = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        sw.start_stop = 1'b0;
        sw.lap        = 1'b0;
        sw.clear      = 1'b0;

        @(negedge clk);
        checkOutput("rst_count",     32'(sw.count),      32'h0);
        checkOutput("rst_display",   32'(sw.display),    32'h0);
        checkOutput("rst_running",   32'(sw.running),    32'h0);
        checkOutput("rst_lapActive", 32'(sw.lap_active), 32'h0);
        checkOutput("rst_overflow",  32'(sw.overflow),   32'h0);
        rst = 1'b0;
        waitCycles(1);

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("start_running", 32'(sw.running), 32'h1);
        checkOutput("start_count",   32'(sw.count),   32'h00);
        waitCycles(3);
        checkOutput("no_early_tick", 32'(sw.count),   32'h00);
        waitCycles(1);
        checkOutput("first_tick",    32'(sw.count),   32'h01);
        waitCycles(36);
        checkOutput("digit_carry",   32'(sw.count),   32'h10);
        checkOutput("run_running",   32'(sw.running), 32'h1);
        waitCycles(356);
        checkOutput("preload_99",    32'(sw.count),    32'h99);
        checkOutput("pre_wrap_ovf",  32'(sw.overflow), 32'h0);
        waitCycles(4);
        checkOutput("wrap_count",    32'(sw.count),    32'h00);
        checkOutput("wrap_ovf",      32'(sw.overflow), 32'h1);
        waitCycles(4);
        checkOutput("post_wrap",     32'(sw.count),    32'h01);
        checkOutput("ovf_sticky",    32'(sw.overflow), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("clr_count",     32'(sw.count),    32'h00);
        checkOutput("clr_ovf",       32'(sw.overflow), 32'h0);
        checkOutput("clr_running",   32'(sw.running),  32'h0);
        waitCycles(6);
        checkOutput("idle_hold",     32'(sw.count),    32'h00);

        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(20);
        checkOutput("lap_pre",       32'(sw.count),      32'h05);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("lap_active",    32'(sw.lap_active), 32'h1);
        checkOutput("lap_display",   32'(sw.display),    32'h05);
        waitCycles(11);
        checkOutput("lap_live",      32'(sw.count),      32'h08);
        checkOutput("lap_frozen",    32'(sw.display),    32'h05);
        checkOutput("lap_running",   32'(sw.running),    32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("unlap_active",  32'(sw.lap_active), 32'h0);
        checkOutput("unlap_display", 32'(sw.display),    32'h08);

        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("stop_running",  32'(sw.running), 32'h0);
        checkOutput("stop_count",    32'(sw.count),   32'h08);
        waitCycles(20);
        checkOutput("stop_hold",     32'(sw.count),   32'h08);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("resume_run",    32'(sw.running), 32'h1);
        waitCycles(1);
        checkOutput("resume_phase1", 32'(sw.count),   32'h08);
        waitCycles(1);
        checkOutput("resume_phase2", 32'(sw.count),   32'h09);

        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(148);
        checkOutput("count_37",      32'(sw.count),   32'h37);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("prio_clr_cnt",  32'(sw.count),   32'h00);
        checkOutput("prio_clr_run",  32'(sw.running), 32'h0);
        checkOutput("prio_clr_disp", 32'(sw.display), 32'h00);
        waitCycles(8);
        checkOutput("prio_clr_idle", 32'(sw.count),   32'h00);

        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(8);
        checkOutput("count_02",      32'(sw.count),      32'h02);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("prio_ss_run",   32'(sw.running),    32'h0);
        checkOutput("prio_ss_lap",   32'(sw.lap_active), 32'h0);
        checkOutput("prio_ss_disp",  32'(sw.display),    32'h02);
        waitCycles(8);
        checkOutput("prio_ss_hold",  32'(sw.count),      32'h02);

        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(48);
        checkOutput("count_12",      32'(sw.count),      32'h12);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("rst_pre_lap",   32'(sw.lap_active), 32'h1);
        checkOutput("rst_pre_disp",  32'(sw.display),    32'h12);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_count",    32'(sw.count),      32'h00);
        checkOutput("arst_display",  32'(sw.display),    32'h00);
        checkOutput("arst_running",  32'(sw.running),    32'h0);
        checkOutput("arst_lap",      32'(sw.lap_active), 32'h0);
        checkOutput("arst_ovf",      32'(sw.overflow),   32'h0);
        @(negedge clk);
        rst = 1'b0;
        waitCycles(10);
        checkOutput("post_rst_idle", 32'(sw.count),      32'h00);
        checkOutput("post_rst_run",  32'(sw.running),    32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(4);
        checkOutput("post_rst_tick", 32'(sw.count),      32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
